// File: rtl/cmm_pkg.sv
// Shared definitions for the complex-matrix datapath output stage: default widths,
// the row serializer state encoding and packed complex field helpers.
package cmm_pkg;

    localparam int CMM_ELEMENT_SIZE = 16;
    localparam int CMM_ROW_LEN      = 4;
    localparam int CMM_HALF         = CMM_ELEMENT_SIZE / 2;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Packed complex element: real part in the upper half, imaginary part in the lower half.
    function automatic logic [CMM_HALF-1:0] cplx_re(input logic [CMM_ELEMENT_SIZE-1:0] e);
        return e[CMM_ELEMENT_SIZE-1:CMM_HALF];
    endfunction

    function automatic logic [CMM_HALF-1:0] cplx_im(input logic [CMM_ELEMENT_SIZE-1:0] e);
        return e[CMM_HALF-1:0];
    endfunction

endpackage

// File: rtl/row_serializer.sv
// Drains one full row of packed complex elements per load beat and streams the
// elements out one per cycle under valid/ready, supporting back-to-back rows.
module row_serializer
    import cmm_pkg::*;
#(
    parameter int ELEMENT_SIZE = CMM_ELEMENT_SIZE,
    parameter int ROW_LEN      = CMM_ROW_LEN,
    localparam int IDX_W       = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            load_valid,
    output logic                            load_ready,
    input  logic [ROW_LEN*ELEMENT_SIZE-1:0] load_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ELEMENT_SIZE-1:0]         out_data,
    output logic [IDX_W-1:0]                out_index,
    output logic                            out_last,
    output logic                            busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

    state_t                          state;
    logic [ROW_LEN*ELEMENT_SIZE-1:0] row_reg;
    logic [IDX_W-1:0]                next_idx;
    logic                            beat;
    logic                            load;

    assign out_valid  = (state == STREAM);
    assign busy       = (state == STREAM);
    assign beat       = out_valid && out_ready;
    // A new row may enter while the final element of the current row is being taken.
    assign load_ready = (state == IDLE) || (beat && out_last);
    assign load       = load_valid && load_ready;
    assign next_idx   = IDX_W'(out_index + 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            row_reg   <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            if (load) begin
                state     <= STREAM;
                row_reg   <= load_data;
                out_data  <= load_data[ELEMENT_SIZE-1:0];
                out_index <= '0;
                out_last  <= (ROW_LEN == 1);
            end else if (beat) begin
                if (out_last) begin
                    state <= IDLE;
                end else begin
                    out_index <= next_idx;
                    out_data  <= row_reg[int'(next_idx)*ELEMENT_SIZE +: ELEMENT_SIZE];
                    out_last  <= (next_idx == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: tb/tb_row_serializer.sv
// Directed and randomized bench for row_serializer: a queue of expected elements
// models the stream; a second instance covers the single-element-row case.
module tb_row_serializer;
    import cmm_pkg::*;

    localparam int ES = 16;
    localparam int RL = 4;

    typedef struct {
        logic [ES-1:0] data;
        int            idx;
        bit            last;
    } elem_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             load_valid;
    logic             load_ready;
    logic [RL*ES-1:0] load_data;
    logic             out_valid;
    logic             out_ready;
    logic [ES-1:0]    out_data;
    logic [1:0]       out_index;
    logic             out_last;
    logic             busy;

    logic             r1_load_valid;
    logic             r1_load_ready;
    logic [ES-1:0]    r1_load_data;
    logic             r1_out_valid;
    logic             r1_out_ready;
    logic [ES-1:0]    r1_out_data;
    logic [0:0]       r1_out_index;
    logic             r1_out_last;
    logic             r1_busy;

    int    errors = 0;
    int    checks = 0;
    elem_t q[$];

    always #5 clk = ~clk;

    row_serializer #(.ELEMENT_SIZE(ES), .ROW_LEN(RL)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    row_serializer #(.ELEMENT_SIZE(ES), .ROW_LEN(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .load_valid(r1_load_valid), .load_ready(r1_load_ready), .load_data(r1_load_data),
        .out_valid(r1_out_valid), .out_ready(r1_out_ready), .out_data(r1_out_data),
        .out_index(r1_out_index), .out_last(r1_out_last), .busy(r1_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One cycle: drive at the falling edge, compare against the queue model, then
    // retire a taken element and enqueue an accepted row as the rising edge will.
    task automatic applyStimulus(input logic lv, input logic [RL*ES-1:0] ld, input logic ordy);
        bit exp_valid;
        bit exp_lr;
        @(negedge clk);
        load_valid = lv;
        load_data  = ld;
        out_ready  = ordy;
        #1;
        exp_valid = (q.size() != 0);
        exp_lr    = (q.size() == 0) || (q.size() == 1 && ordy);
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        checkOutput("busy", 32'(busy), 32'(exp_valid));
        checkOutput("load_ready", 32'(load_ready), 32'(exp_lr));
        if (exp_valid) begin
            checkOutput("out_data", 32'(out_data), 32'(q[0].data));
            checkOutput("out_index", 32'(out_index), 32'(q[0].idx));
            checkOutput("out_last", 32'(out_last), 32'(q[0].last));
            if (ordy) void'(q.pop_front());
        end
        if (lv && exp_lr) begin
            for (int k = 0; k < RL; k++) begin
                q.push_back('{data: ld[k*ES +: ES], idx: k, last: (k == RL - 1)});
            end
        end
    endtask

    initial begin
        logic [RL*ES-1:0] row_a;
        logic [RL*ES-1:0] row_b;
        logic [RL*ES-1:0] row_f;
        logic [ES-1:0]    r1_rows [3];

        row_a = {16'h0404, 16'h0303, 16'h0202, 16'h0101};
        row_b = {16'hA4A4, 16'hA3A3, 16'hA2A2, 16'hA1A1};
        row_f = {RL{16'hFFFF}};
        r1_rows[0] = 16'h1111;
        r1_rows[1] = 16'h2222;
        r1_rows[2] = 16'h3333;

        reset_n = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        out_ready = 1'b0;
        r1_load_valid = 1'b0;
        r1_load_data = '0;
        r1_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_index", 32'(out_index), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        reset_n = 1'b1;

        $display("[TB] basic row");
        applyStimulus(1'b1, row_a, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("basic_re0", 32'(cplx_re(out_data)), 32'h01);
        checkOutput("basic_im0", 32'(cplx_im(out_data)), 32'h01);
        repeat (3) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);

        $display("[TB] stall at index 1");
        applyStimulus(1'b1, row_a, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        repeat (3) begin
            applyStimulus(1'b1, row_b, 1'b0);
            checkOutput("stall_data", 32'(out_data), 32'h0202);
            checkOutput("stall_index", 32'(out_index), 32'd1);
        end
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("resume_data", 32'(out_data), 32'h0303);

        $display("[TB] back-to-back rows");
        applyStimulus(1'b1, row_b, 1'b1);
        checkOutput("b2b_last_data", 32'(out_data), 32'h0404);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("b2b_first_data", 32'(out_data), 32'hA1A1);

        $display("[TB] load offered mid-row");
        applyStimulus(1'b1, row_f, 1'b1);
        applyStimulus(1'b1, row_f, 1'b1);
        checkOutput("ign_data", 32'(out_data), 32'hA3A3);
        applyStimulus(1'b1, row_f, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("ign_new_row", 32'(out_data), 32'hFFFF);

        $display("[TB] reset mid-row");
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        load_valid = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("midrst_out_index", 32'(out_index), 32'd0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                          1'($urandom_range(0, 3) != 0));
        end
        while (q.size() != 0 && checks < 20000) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);

        $display("[TB] single-element rows");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r1_out_ready  = 1'b1;
            r1_load_valid = (i < 3);
            r1_load_data  = (i < 3) ? r1_rows[i] : '0;
            #1;
            checkOutput("r1_load_ready", 32'(r1_load_ready), 32'd1);
            if (i > 0) begin
                checkOutput("r1_out_valid", 32'(r1_out_valid), 32'd1);
                checkOutput("r1_out_data", 32'(r1_out_data), 32'(r1_rows[i-1]));
                checkOutput("r1_out_last", 32'(r1_out_last), 32'd1);
                checkOutput("r1_out_index", 32'(r1_out_index), 32'd0);
            end
        end
        @(negedge clk);
        r1_load_valid = 1'b0;
        #1;
        checkOutput("r1_drained", 32'(r1_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
